phy_rx_serial_align: RTL and testbench

Serial-to-parallel receive aligner for one PHY lane. It runs on the bit clock and accepts the 1-bit stream produced by the transmit serializer. It finds byte alignment using the comma symbol and declares lock after a run of aligned commas. It then delivers 8-bit bytes with a valid flag to the receive-side byte-domain logic, with commas stripped as idle.

---
 rtl/phy_pkg.sv | 19 +
 rtl/phy_rx_shift8.sv | 36 +++
 rtl/phy_rx_serial_align.sv | 124 ++++++++++++
 tb/tb_phy_rx_serial_align.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_pkg
//  Description : Shared PHY definitions: comma symbol used by the transmit
//                serializer and receive aligner, and receive FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

  // Alignment / idle symbol shared by both link directions
  localparam logic [7:0] PHY_COMMA = 8'hBC;

  // Receive aligner state encoding
  localparam logic [1:0] RX_SEARCH = 2'd0;
  localparam logic [1:0] RX_COUNT  = 2'd1;
  localparam logic [1:0] RX_ACTIVE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/phy_rx_shift8.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_shift8
//  Description : 8-bit receive shift register. Exposes the value the register
//                takes on the coming edge and whether that value is a comma.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_shift8
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA = PHY_COMMA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_data,
  output logic [7:0] o_next_sr,
  output logic       o_comma_match
);

  logic [7:0] r_sr;

  // Serial data arrives MSB first, so new bits enter at the LSB end
  assign o_next_sr     = {r_sr[6:0], i_data};
  assign o_comma_match = (o_next_sr == COMMA);

  // Shift every cycle regardless of alignment state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= 8'h00;
    end else begin
      r_sr <= o_next_sr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/phy_rx_serial_align.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_serial_align
//  Description : Serial-to-parallel receive aligner for one PHY lane. Finds
//                byte alignment on the comma symbol, locks after LOCK_COUNT
//                aligned commas, then delivers bytes with commas as idle.
//                Optional macro RX_RESYNC_EN: a misaligned comma seen while
//                ACTIVE drops lock and restarts counting on the new phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_serial_align
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA      = PHY_COMMA, // must be nonzero
  parameter int unsigned LOCK_COUNT = 4          // legal range 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [4:0] c_lock_count = 5'(LOCK_COUNT);

  logic [1:0] r_state;
  logic [2:0] r_phase;
  logic [3:0] r_cnt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_strobe;

  logic [7:0] w_next_sr;
  logic       w_match;
  logic       w_boundary;
  logic [4:0] w_cnt_inc;

  phy_rx_shift8 #(
    .COMMA (COMMA)
  ) u_shift (
    .clk           (clk),
    .reset         (reset),
    .i_data        (data_in),
    .o_next_sr     (w_next_sr),
    .o_comma_match (w_match)
  );

  assign w_boundary = (r_phase == 3'd7);
  // Widened so the lock comparison cannot wrap at LOCK_COUNT=15
  assign w_cnt_inc  = {1'b0, r_cnt} + 5'd1;

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_strobe = r_strobe;
  assign active      = (r_state == RX_ACTIVE);

  // Alignment FSM with phase/lock counters and byte output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RX_SEARCH;
      r_phase  <= 3'd0;
      r_cnt    <= 4'd0;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        RX_SEARCH: begin
          if (w_match) begin
            r_cnt   <= 4'd1;
            r_phase <= 3'd0;
            r_state <= (c_lock_count == 5'd1) ? RX_ACTIVE : RX_COUNT;
          end
        end
        RX_COUNT: begin
          r_phase <= r_phase + 3'd1;
          // Commas off the byte grid are ignored while counting
          if (w_boundary) begin
            if (w_match) begin
              r_cnt <= w_cnt_inc[3:0];
              // >= lets a LOCK_COUNT of 1 relock after a resync
              if (w_cnt_inc >= c_lock_count) begin
                r_state <= RX_ACTIVE;
              end
            end else begin
              r_cnt   <= 4'd0;
              r_state <= RX_SEARCH;
            end
          end
        end
        RX_ACTIVE: begin
          r_phase <= r_phase + 3'd1;
          if (w_boundary) begin
            r_strobe <= 1'b1;
            if (w_match) begin
              r_valid <= 1'b0;
            end else begin
              r_data  <= w_next_sr;
              r_valid <= 1'b1;
            end
          end
`ifdef RX_RESYNC_EN
          else if (w_match) begin
            // Comma on a new phase: drop lock and count on that phase
            r_state <= RX_COUNT;
            r_cnt   <= 4'd1;
            r_phase <= 3'd0;
            r_valid <= 1'b0;
          end
`endif
        end
        default: begin
          r_state <= RX_SEARCH;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_serial_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_rx_serial_align
//  Description : Self-checking bench for phy_rx_serial_align. Two lanes share
//                the serial stream: LOCK_COUNT=4 and LOCK_COUNT=1. Expected
//                outputs come from a byte-level model of the lock rules.
//                Honours RX_RESYNC_EN for the slip scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_rx_serial_align;

  localparam logic [7:0] c_comma = 8'hBC;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d1_valid;
  logic       d0_stb, d1_stb;
  logic       d0_act, d1_act;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b1;

  // Byte-level reference model, one slot per lane
  int         lockc [2] = '{4, 1};
  logic       m_act [2];
  logic [7:0] m_dat [2];
  logic       m_val [2];
  logic       m_stb [2];
  int         m_cnt [2];

  phy_rx_serial_align #(.COMMA(8'hBC), .LOCK_COUNT(4)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_out(d0_data), .valid_out(d0_valid),
    .byte_strobe(d0_stb), .active(d0_act)
  );

  phy_rx_serial_align #(.COMMA(8'hBC), .LOCK_COUNT(1)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_out(d1_data), .valid_out(d1_valid),
    .byte_strobe(d1_stb), .active(d1_act)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_dat[i] = 8'h00;
      m_val[i] = 1'b0;
      m_stb[i] = 1'b0;
      m_cnt[i] = 0;
    end
  endtask

  // A whole byte completed on the sender's grid
  task automatic model_byte(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      m_stb[i] = 1'b0;
      if (m_act[i]) begin
        m_stb[i] = 1'b1;
        if (b == c_comma) begin
          m_val[i] = 1'b0;
        end else begin
          m_dat[i] = b;
          m_val[i] = 1'b1;
        end
      end else if (b == c_comma) begin
        m_cnt[i]++;
        if (m_cnt[i] >= lockc[i]) m_act[i] = 1'b1;
      end else begin
        m_cnt[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    if (check_en) begin
      chk({tag, "/u0.data"},   d0_data,         m_dat[0]);
      chk({tag, "/u0.valid"},  {7'd0, d0_valid}, {7'd0, m_val[0]});
      chk({tag, "/u0.strobe"}, {7'd0, d0_stb},   {7'd0, m_stb[0]});
      chk({tag, "/u0.active"}, {7'd0, d0_act},   {7'd0, m_act[0]});
      chk({tag, "/u1.data"},   d1_data,         m_dat[1]);
      chk({tag, "/u1.valid"},  {7'd0, d1_valid}, {7'd0, m_val[1]});
      chk({tag, "/u1.strobe"}, {7'd0, d1_stb},   {7'd0, m_stb[1]});
      chk({tag, "/u1.active"}, {7'd0, d1_act},   {7'd0, m_act[1]});
    end
  endtask

  task automatic send_bit(input logic b, input string tag);
    @(negedge clk) data_in = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) m_stb[i] = 1'b0;
    check_all(tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk) data_in = b[k];
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) m_stb[i] = 1'b0;
      if (k == 0) model_byte(b);
      check_all(tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    data_in = 1'b0;
    reset   = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk) reset = 1'b0;
  endtask

  logic [7:0] rnd;
  logic       exp_act [4];

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_state");
    @(negedge clk) reset = 1'b0;

    // Clean lock: lane0 after 4 commas, lane1 after the first
    for (int n = 0; n < 4; n++) send_byte(c_comma, "lock");
    chk("lock4_active", {7'd0, d0_act}, 8'd1);

    // Data, idle comma, data
    send_byte(8'h5A, "d5A");
    chk("d5A_data", d0_data, 8'h5A);
    send_byte(c_comma, "idle");
    chk("idle_hold", d0_data, 8'h5A);
    chk("idle_valid", {7'd0, d0_valid}, 8'd0);
    send_byte(8'hC3, "dC3");
    chk("dC3_data", d0_data, 8'hC3);

    // Random payload
    for (int n = 0; n < 20; n++) begin
      rnd = 8'($urandom);
      send_byte(rnd, "rand");
    end

    // Asynchronous reset in the middle of a byte
    send_bit(1'b1, "part");
    send_bit(1'b0, "part");
    send_bit(1'b1, "part");
    #2;
    data_in = 1'b0;
    reset   = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) reset = 1'b0;

    // Three-bit offset, then commas: lock on the shifted grid
    send_bit(1'b1, "pre");
    send_bit(1'b0, "pre");
    send_bit(1'b1, "pre");
    for (int n = 0; n < 4; n++) send_byte(c_comma, "shift_lock");
    chk("shift_active", {7'd0, d0_act}, 8'd1);
    for (int n = 0; n < 6; n++) begin
      rnd = 8'($urandom);
      send_byte(rnd, "shift_rand");
    end

    // Broken comma run during counting forces a fresh search
    pulse_reset("rst2");
    send_byte(c_comma, "abort");
    send_byte(c_comma, "abort");
    send_byte(8'h00, "abort");
    for (int n = 0; n < 3; n++) send_byte(c_comma, "relock");
    chk("abort_no_lock", {7'd0, d0_act}, 8'd0);
    send_byte(c_comma, "relock");
    chk("abort_relock", {7'd0, d0_act}, 8'd1);

    // One slip bit then commas on the new phase
`ifdef RX_RESYNC_EN
    exp_act = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_act = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    check_en = 1'b0;
    send_bit(1'b0, "slip");
    for (int n = 0; n < 4; n++) begin
      send_byte(c_comma, "slip");
      chk($sformatf("slip_active_%0d", n), {7'd0, d0_act}, {7'd0, exp_act[n]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
